// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// Generic elastic register that sits between two MIPS pipeline stages
// (IF/ID, ID/EX, EX/MEM, MEM/WB). It holds one {data, ctrl} entry in a main
// register, which drives the outputs. A one-entry skid register catches the
// entry that arrives in the same cycle the downstream stalls, so O_READY can
// come straight from a flop.
//
// Handshake (both sides): a transfer happens on a rising CLK edge where
// valid and ready are both 1. The sender keeps valid and payload stable
// until that edge. Ready never depends combinationally on valid.
//   accept = I_VALID & O_READY   (upstream -> this stage)
//   emit   = O_VALID & I_READY   (this stage -> downstream)
//
// I_FLUSH is synchronous and has the highest priority. The stage goes empty
// and the entry presented in that cycle is dropped. An emit in the same
// cycle still counts as delivered.
//
// Optional feature: define PIPE_STAGE_PERF_EN to add the saturating 16-bit
// counters O_STALL_CNT and O_FLUSH_CNT.
//
// Parameters:
//   DATA_W      datapath payload width (PC, operands, immediates, reg ids)
//   CTRL_W      control payload width; forced to zero on a bubble
// Ports:
//   CLK         rising-edge clock
//   RESET_N     asynchronous active-low reset
//   I_FLUSH     synchronous flush
//   I_VALID     upstream entry valid
//   O_READY     this stage can accept (registered)
//   I_DATA      upstream datapath payload
//   I_CTRL      upstream control payload
//   O_VALID     output entry valid (registered)
//   I_READY     downstream accepts
//   O_DATA      registered datapath payload
//   O_CTRL      registered control payload; zero whenever O_VALID = 0
//   O_STALL_CNT cycles with O_VALID=1 and I_READY=0 (PIPE_STAGE_PERF_EN only)
//   O_FLUSH_CNT cycles with I_FLUSH=1               (PIPE_STAGE_PERF_EN only)
//   O_DBG_STATE current occupancy state, for debug and checker binding
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 20
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              I_FLUSH,
  input  logic              I_VALID,
  output logic              O_READY,
  input  logic [DATA_W-1:0] I_DATA,
  input  logic [CTRL_W-1:0] I_CTRL,
  output logic              O_VALID,
  input  logic              I_READY,
  output logic [DATA_W-1:0] O_DATA,
  output logic [CTRL_W-1:0] O_CTRL,
`ifdef PIPE_STAGE_PERF_EN
  output logic [15:0]       O_STALL_CNT,
  output logic [15:0]       O_FLUSH_CNT,
`endif
  output logic [1:0]        O_DBG_STATE
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,  // nothing held
    ST_FULL  = 2'd1,  // main holds the entry on the outputs
    ST_SKID  = 2'd2   // main and skid both hold entries; upstream is stalled
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic                valid_q, valid_d;
  logic                ready_q, ready_d;

  logic                accept;
  logic                emit;

  assign accept = I_VALID & ready_q;
  assign emit   = valid_q & I_READY;

  // ---------------------------------------------------------------------------
  // Next-state and storage update
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;

    if (I_FLUSH) begin
      // Flush wins over every handshake. Data is left as is; only the control
      // payload has to become a bubble.
      state_d     = ST_EMPTY;
      main_ctrl_d = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_data_d = I_DATA;
            main_ctrl_d = I_CTRL;
            state_d     = ST_FULL;
          end
        end

        ST_FULL: begin
          if (accept && emit) begin
            // Pass-through at full rate: main is replaced by the new entry.
            main_data_d = I_DATA;
            main_ctrl_d = I_CTRL;
          end else if (accept) begin
            // Downstream stalled in the same cycle an entry arrived. Park the
            // new entry behind main and drop ready on the next cycle.
            skid_data_d = I_DATA;
            skid_ctrl_d = I_CTRL;
            state_d     = ST_SKID;
          end else if (emit) begin
            main_ctrl_d = '0;
            state_d     = ST_EMPTY;
          end
        end

        ST_SKID: begin
          // ready_q is 0 here, so no accept can happen.
          if (emit) begin
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
            state_d     = ST_FULL;
          end
        end

        default: begin
          main_ctrl_d = '0;
          state_d     = ST_EMPTY;
        end
      endcase
    end

    // The handshake flags are registered copies of the decoded next state.
    // Neither output then has a path from any input.
    valid_d = (state_d != ST_EMPTY);
    ready_d = (state_d != ST_SKID);
  end

  // ---------------------------------------------------------------------------
  // State and payload registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      valid_q     <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      valid_q     <= valid_d;
      ready_q     <= ready_d;
    end
  end

  assign O_VALID     = valid_q;
  assign O_READY     = ready_q;
  assign O_DATA      = main_data_q;
  assign O_CTRL      = main_ctrl_q;
  assign O_DBG_STATE = state_q;

`ifdef PIPE_STAGE_PERF_EN
  // ---------------------------------------------------------------------------
  // Saturating performance counters
  // ---------------------------------------------------------------------------
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (valid_q && !I_READY && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    if (I_FLUSH && (flush_cnt_q != 16'hFFFF)) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign O_STALL_CNT = stall_cnt_q;
  assign O_FLUSH_CNT = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Bench for pipe_stage_reg. Inputs are driven 1 time unit after each rising
// edge. Per-vector checks sample 1 unit after the next rising edge. The
// scoreboard monitor samples on the falling edge.
//
// The scoreboard keeps every accepted entry in exp_q. O_VALID, O_READY and
// the head of the queue are then checked against the queue occupancy on
// every cycle.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

  localparam int DATA_W = 128;
  localparam int CTRL_W = 20;
  localparam int W      = DATA_W + CTRL_W;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic              clk;
  logic              rst_n;
  logic              i_flush;
  logic              i_valid;
  logic              o_ready;
  logic [DATA_W-1:0] i_data;
  logic [CTRL_W-1:0] i_ctrl;
  logic              o_valid;
  logic              i_ready;
  logic [DATA_W-1:0] o_data;
  logic [CTRL_W-1:0] o_ctrl;
  logic [1:0]        o_dbg_state;
`ifdef PIPE_STAGE_PERF_EN
  logic [15:0]       o_stall_cnt;
  logic [15:0]       o_flush_cnt;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
    .CLK         (clk),
    .RESET_N     (rst_n),
    .I_FLUSH     (i_flush),
    .I_VALID     (i_valid),
    .O_READY     (o_ready),
    .I_DATA      (i_data),
    .I_CTRL      (i_ctrl),
    .O_VALID     (o_valid),
    .I_READY     (i_ready),
    .O_DATA      (o_data),
    .O_CTRL      (o_ctrl),
`ifdef PIPE_STAGE_PERF_EN
    .O_STALL_CNT (o_stall_cnt),
    .O_FLUSH_CNT (o_flush_cnt),
`endif
    .O_DBG_STATE (o_dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_head;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      check("sb_o_valid", {147'd0, o_valid}, {147'd0, exp_q.size() > 0});
      check("sb_o_ready", {147'd0, o_ready}, {147'd0, exp_q.size() < 2});
      if (!o_valid) begin
        check("sb_bubble_ctrl", {128'd0, o_ctrl}, '0);
      end else if (exp_q.size() > 0) begin
        mon_head = exp_q[0];
        check("sb_o_data", {20'd0, o_data}, {20'd0, mon_head[W-1:CTRL_W]});
        check("sb_o_ctrl", {128'd0, o_ctrl}, {128'd0, mon_head[CTRL_W-1:0]});
      end
      if (o_valid && i_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (i_flush) exp_q.delete();
      else if (i_valid && o_ready) exp_q.push_back({i_data, i_ctrl});
    end
  end

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        vld;
    logic [7:0]  data;
    logic [19:0] ctrl;
    logic        rdy;
    logic        flush;
    logic        exp_vld;
    logic        exp_rdy;
    logic [7:0]  exp_data;
    logic [19:0] exp_ctrl;
  } vec_t;

  localparam int N_VEC = 19;
  vec_t vecs[N_VEC];

  function automatic vec_t mk(input logic vld, input logic [7:0] data, input logic [19:0] ctrl,
                              input logic rdy, input logic flush, input logic ev, input logic er,
                              input logic [7:0] ed, input logic [19:0] ec);
    vec_t v;
    v.vld = vld; v.data = data; v.ctrl = ctrl; v.rdy = rdy; v.flush = flush;
    v.exp_vld = ev; v.exp_rdy = er; v.exp_data = ed; v.exp_ctrl = ec;
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks (called at rising edge + 1)
  // ---------------------------------------------------------------------------
  task automatic drive(input logic vld, input logic [DATA_W-1:0] data, input logic [CTRL_W-1:0] ctrl,
                       input logic rdy, input logic flush);
    i_valid = vld;
    i_data  = data;
    i_ctrl  = ctrl;
    i_ready = rdy;
    i_flush = flush;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    drive(v.vld, {120'd0, v.data}, v.ctrl, v.rdy, v.flush);
    check($sformatf("vec%0d_o_valid", idx), {147'd0, o_valid}, {147'd0, v.exp_vld});
    check($sformatf("vec%0d_o_ready", idx), {147'd0, o_ready}, {147'd0, v.exp_rdy});
    check($sformatf("vec%0d_o_data", idx), {20'd0, o_data}, {140'd0, v.exp_data});
    check($sformatf("vec%0d_o_ctrl", idx), {128'd0, o_ctrl}, {128'd0, v.exp_ctrl});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  logic              r_vld;
  logic              r_rdy;
  logic              r_flush;
  logic [DATA_W-1:0] r_data;
  logic [CTRL_W-1:0] r_ctrl;

  initial begin
    //            vld data  ctrl rdy fl   ev er  edata ectrl
    vecs[0]  = mk(1, 8'h01, 20'h1, 1, 0,  1, 1, 8'h01, 20'h1);
    vecs[1]  = mk(1, 8'h02, 20'h2, 1, 0,  1, 1, 8'h02, 20'h2);
    vecs[2]  = mk(1, 8'h03, 20'h3, 1, 0,  1, 1, 8'h03, 20'h3);
    vecs[3]  = mk(1, 8'h04, 20'h4, 1, 0,  1, 1, 8'h04, 20'h4);
    vecs[4]  = mk(0, 8'h00, 20'h0, 1, 0,  0, 1, 8'h04, 20'h0);
    vecs[5]  = mk(0, 8'h00, 20'h0, 1, 0,  0, 1, 8'h04, 20'h0);
    vecs[6]  = mk(0, 8'h00, 20'h0, 1, 0,  0, 1, 8'h04, 20'h0);
    vecs[7]  = mk(1, 8'h0A, 20'hA, 0, 0,  1, 1, 8'h0A, 20'hA);
    vecs[8]  = mk(1, 8'h0B, 20'hB, 0, 0,  1, 0, 8'h0A, 20'hA);
    vecs[9]  = mk(1, 8'h0B, 20'hB, 0, 0,  1, 0, 8'h0A, 20'hA);
    vecs[10] = mk(0, 8'h00, 20'h0, 1, 0,  1, 1, 8'h0B, 20'hB);
    vecs[11] = mk(0, 8'h00, 20'h0, 1, 0,  0, 1, 8'h0B, 20'h0);
    vecs[12] = mk(1, 8'h05, 20'h5, 0, 0,  1, 1, 8'h05, 20'h5);
    vecs[13] = mk(1, 8'h06, 20'h6, 0, 0,  1, 0, 8'h05, 20'h5);
    vecs[14] = mk(1, 8'h0C, 20'hC, 0, 1,  0, 1, 8'h05, 20'h0);
    vecs[15] = mk(0, 8'h00, 20'h0, 1, 0,  0, 1, 8'h05, 20'h0);
    vecs[16] = mk(1, 8'h07, 20'h7, 1, 0,  1, 1, 8'h07, 20'h7);
    vecs[17] = mk(1, 8'h08, 20'h8, 1, 1,  0, 1, 8'h07, 20'h0);
    vecs[18] = mk(0, 8'h00, 20'h0, 1, 0,  0, 1, 8'h07, 20'h0);

    i_valid = 1'b0;
    i_ready = 1'b0;
    i_flush = 1'b0;
    i_data  = '0;
    i_ctrl  = '0;
    rst_n   = 1'b0;

    // Reset values
    #12;
    check("reset_o_valid", {147'd0, o_valid}, '0);
    check("reset_o_ready", {147'd0, o_ready}, {147'd0, 1'b1});
    check("reset_o_data", {20'd0, o_data}, '0);
    check("reset_o_ctrl", {128'd0, o_ctrl}, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed table: streaming, backpressure into skid, flush corners
    for (int i = 0; i < N_VEC; i++) apply_vec(vecs[i], i);

    // Random traffic. A stalled upstream entry keeps its valid and payload
    // until it is taken.
    r_vld = 1'b0;
    r_data = '0;
    r_ctrl = '0;
    for (int c = 0; c < 400; c++) begin
      if (!(r_vld && !o_ready)) begin
        r_vld  = ($urandom_range(0, 3) != 0);
        r_data = {$urandom, $urandom, $urandom, $urandom};
        r_ctrl = CTRL_W'($urandom);
      end
      r_rdy   = ($urandom_range(0, 2) != 0);
      r_flush = ($urandom_range(0, 15) == 0);
      drive(r_vld, r_data, r_ctrl, r_rdy, r_flush);
    end
    repeat (3) drive(1'b0, '0, '0, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a cycle while FULL
    drive(1'b1, 128'h99, 20'h99, 1'b0, 1'b0);
    check("pre_areset_o_valid", {147'd0, o_valid}, {147'd0, 1'b1});
    check("pre_areset_o_data", {20'd0, o_data}, {20'd0, 128'h99});
    i_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_o_valid", {147'd0, o_valid}, '0);
    check("areset_o_ready", {147'd0, o_ready}, {147'd0, 1'b1});
    check("areset_o_data", {20'd0, o_data}, '0);
    check("areset_o_ctrl", {128'd0, o_ctrl}, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    check("post_areset_o_valid", {147'd0, o_valid}, '0);

`ifdef PIPE_STAGE_PERF_EN
    do_reset();
    check("perf_reset_stall", {132'd0, o_stall_cnt}, '0);
    check("perf_reset_flush", {132'd0, o_flush_cnt}, '0);
    drive(1'b1, 128'h11, 20'h11, 1'b0, 1'b0);
    repeat (5) drive(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (2) drive(1'b0, '0, '0, 1'b1, 1'b1);
    check("perf_stall_5", {132'd0, o_stall_cnt}, {132'd0, 16'd5});
    check("perf_flush_2", {132'd0, o_flush_cnt}, {132'd0, 16'd2});
    drive(1'b1, 128'h22, 20'h22, 1'b0, 1'b0);
    repeat (70000) drive(1'b0, '0, '0, 1'b0, 1'b0);
    check("perf_stall_sat", {132'd0, o_stall_cnt}, {132'd0, 16'hFFFF});
    check("perf_flush_hold", {132'd0, o_flush_cnt}, {132'd0, 16'd2});
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    do_reset();
    check("perf_rereset_stall", {132'd0, o_stall_cnt}, '0);
`endif

    drive(1'b0, '0, '0, 1'b1, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
